// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: turns a level-style byte-complete flag into a
// single push per byte, buffers bytes in a DEPTH-entry first-word-fall-through
// queue and flags bytes lost to a full queue with a sticky overflow bit.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          rx_byte_done,
  input  logic [7:0]    rx_data,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic          done_q, done_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // Outputs are derived from state only; no same-cycle bypass from rx_data.
  assign m_valid    = (count_q != '0);
  assign fifo_full  = (count_q == FullCount);
  assign m_data     = mem_q[rp_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  // Edge detect, push/pop decode and next-state for pointers, count, overflow.
  always_comb begin
    done_d  = rx_byte_done;
    push    = rx_byte_done & ~done_q;
    pop     = m_valid & m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    wr_en   = push & (~fifo_full | pop);
    drop    = push & fifo_full & ~pop;

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (wr_en) begin
      wp_d = wp_q + PtrOne;
    end
    if (pop) begin
      rp_d = rp_q + PtrOne;
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop in the clear cycle is not lost.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem_q[wp_q] <= rx_data;
    end
  end

  // Occupancy must stay within 0..DEPTH.
  a_count_bound : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    count_q <= FullCount);

  // Pointer distance must agree with the occupancy counter.
  a_ptr_count : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (count_q == FullCount) || (AW'(wp_q - rp_q) == count_q[AW-1:0]));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario, inline comparisons.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          rx_byte_done;
  logic [7:0]    rx_data;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          overflow;
  logic          clr_ovf;

  int n_checks;
  int n_fail;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rx_byte_done (rx_byte_done),
    .rx_data      (rx_data),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Advance one clock and sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One byte: flag high for one cycle, then low for one cycle.
  task automatic push_byte(input logic [7:0] d);
    rx_data      = d;
    rx_byte_done = 1'b1;
    tick();
    rx_byte_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b count=%0d full=%b ovf=%b, required 0/0/0/0",
               m_valid, fifo_count, fifo_full, overflow);
    end
    sys_rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 5'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_when_empty: count=%0d valid=%b, required 0/0", fifo_count, m_valid);
    end
  endtask

  task automatic test_long_flag();
    rx_data      = 8'hA5;
    rx_byte_done = 1'b1;
    tick();
    n_checks++;
    if (m_valid !== 1'b1 || fifo_count !== 5'd1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL long_flag_first: valid=%b count=%0d data=%h, required 1/1/a5",
               m_valid, fifo_count, m_data);
    end
    // Data changes while the flag stays high must not be captured.
    rx_data = 8'h3C;
    repeat (216) tick();
    rx_byte_done = 1'b0;
    tick();
    n_checks++;
    if (fifo_count !== 5'd1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL long_flag_single: count=%0d data=%h, required 1/a5", fifo_count, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL long_flag_drain: valid=%b count=%0d, required 0/0", m_valid, fifo_count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
    end
    n_checks++;
    if (fifo_full !== 1'b1 || fifo_count !== 5'd16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b, required 1/16/0",
               fifo_full, fifo_count, overflow);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h, required 1/%h", i, m_valid, m_data,
                 8'(i));
      end
      tick();
    end
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b count=%0d full=%b, required 0/0/0",
               m_valid, fifo_count, fifo_full);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
    end
    push_byte(8'h55);
    n_checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_drop: count=%0d ovf=%b head=%h, required 16/1/00",
               fifo_count, overflow, m_data);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || m_data !== 8'h00 || fifo_count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b head=%h count=%0d, required 0/00/16",
               overflow, m_data, fifo_count);
    end
    // Clear and new drop in the same cycle: set wins.
    rx_data      = 8'h66;
    rx_byte_done = 1'b1;
    clr_ovf      = 1'b1;
    tick();
    rx_byte_done = 1'b0;
    clr_ovf      = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b count=%0d, required 1/16", overflow, fifo_count);
    end
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear2: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    rx_data      = 8'h77;
    rx_byte_done = 1'b1;
    m_ready      = 1'b1;
    tick();
    rx_byte_done = 1'b0;
    m_ready      = 1'b0;
    n_checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0 || m_data !== 8'h01) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head=%h, required 16/0/01",
               fifo_count, overflow, m_data);
    end
    tick();
    m_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (m_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL fpp_order[%0d]: data=%h, required %h", i, m_data, 8'(i));
      end
      tick();
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h77) begin
      n_fail++;
      $display("FAIL fpp_last: valid=%b data=%h, required 1/77", m_valid, m_data);
    end
    tick();
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL fpp_empty: valid=%b count=%0d, required 0/0", m_valid, fifo_count);
    end
  endtask

  task automatic test_wraparound();
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         sent;
    int         cyc;
    logic       pop_now;
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || exp_q.size() != 0) && cyc < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      pop_now = m_valid && m_ready;
      if (pop_now) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_extra: data=%h, required no entry", m_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (m_data !== exp_b) begin
            n_fail++;
            $display("FAIL wrap_data: data=%h, required %h", m_data, exp_b);
          end
        end
      end
      // Only start a byte when it cannot be dropped.
      if (!rx_byte_done && sent < 40 && (fifo_count < 5'd16 || pop_now)) begin
        rx_data      = 8'(sent * 37 + 5);
        rx_byte_done = 1'b1;
        exp_q.push_back(rx_data);
        sent++;
      end else begin
        rx_byte_done = 1'b0;
      end
      n_checks++;
      if (fifo_count > 5'd16) begin
        n_fail++;
        $display("FAIL wrap_count: count=%0d, required <=16", fifo_count);
      end
      tick();
      cyc++;
    end
    m_ready      = 1'b0;
    rx_byte_done = 1'b0;
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL wrap_timeout: cycles=%0d, required <3000", cyc);
    end
    n_checks++;
    if (fifo_count !== 5'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: count=%0d ovf=%b, required 0/0", fifo_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h10 + 8'(i));
    end
    n_checks++;
    if (fifo_count !== 5'd5 || m_data !== 8'h10) begin
      n_fail++;
      $display("FAIL pre_reset: count=%0d head=%h, required 5/10", fifo_count, m_data);
    end
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b count=%0d, required 0/0", m_valid, fifo_count);
    end
    // Flag already high when reset releases counts as a new byte.
    rx_data      = 8'h9A;
    rx_byte_done = 1'b1;
    tick();
    sys_rst_n = 1'b1;
    tick();
    n_checks++;
    if (fifo_count !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'h9A) begin
      n_fail++;
      $display("FAIL post_reset_push: count=%0d valid=%b data=%h, required 1/1/9a",
               fifo_count, m_valid, m_data);
    end
    tick();
    rx_byte_done = 1'b0;
    tick();
    n_checks++;
    if (fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_single: count=%0d, required 1", fifo_count);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    sys_rst_n    = 1'b0;
    rx_byte_done = 1'b0;
    rx_data      = 8'h00;
    m_ready      = 1'b0;
    clr_ovf      = 1'b0;
    test_reset();
    test_long_flag();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_wraparound();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
